imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender: S1 captures mode and instruction bits, S2 forms the
// extended immediate and rotator carry and holds them under a valid/ready handshake.
module imm_extend_pipe #(
   parameter int XLEN     = 32,
   parameter int BR_SHIFT = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [23:0]      Instr,
   input  logic [2:0]       ImmSrc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ExtImm,
   output logic             ExtCarry,
   output logic             ExtErr,
   output logic [CNT_W-1:0] err_count
);

   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_mode_q, s1_mode_d;
   logic [23:0]      s1_instr_q, s1_instr_d;
   logic             s2_valid_q, s2_valid_d;
   logic [XLEN-1:0]  ext_imm_q, ext_imm_d;
   logic             ext_carry_q, ext_carry_d;
   logic             ext_err_q, ext_err_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic             accept;
   logic             s2_load;
   logic             out_xfer;
   logic [XLEN-1:0]  imm_calc;
   logic             carry_calc;
   logic             err_calc;
   logic [4:0]       rot_amt;
   logic [63:0]      rot_wide;
   logic [XLEN-1:0]  br_ext;

   assign in_ready = !flush && (!s1_valid_q || !s2_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
   assign out_xfer = s2_valid_q && out_ready;

   assign out_valid = s2_valid_q;
   assign ExtImm    = ext_imm_q;
   assign ExtCarry  = ext_carry_q;
   assign ExtErr    = ext_err_q;
   assign err_count = err_count_q;

   always_comb begin
      imm_calc   = '0;
      carry_calc = 1'b0;
      err_calc   = 1'b0;
      rot_amt    = {s1_instr_q[11:8], 1'b0};
      // Shifting a doubled copy right leaves the 32-bit rotate in the low word.
      rot_wide   = {24'd0, s1_instr_q[7:0], 24'd0, s1_instr_q[7:0]} >> rot_amt;
      br_ext     = {{(XLEN-24){s1_instr_q[23]}}, s1_instr_q} << BR_SHIFT;
      case (s1_mode_q)
         3'b000: begin
            imm_calc[31:0] = rot_wide[31:0];
            carry_calc     = (rot_amt != 5'd0) && rot_wide[31];
         end
         3'b001:  imm_calc = {{(XLEN-12){1'b0}}, s1_instr_q[11:0]};
         3'b010:  imm_calc = br_ext;
         3'b011:  imm_calc = {{(XLEN-8){s1_instr_q[7]}}, s1_instr_q[7:0]};
         3'b100:  imm_calc = {{(XLEN-12){s1_instr_q[11]}}, s1_instr_q[11:0]};
         3'b101:  imm_calc = {{(XLEN-16){1'b0}}, s1_instr_q[19:16], s1_instr_q[11:0]};
         default: err_calc = 1'b1;
      endcase
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_mode_d   = s1_mode_q;
      s1_instr_d  = s1_instr_q;
      s2_valid_d  = s2_valid_q;
      ext_imm_d   = ext_imm_q;
      ext_carry_d = ext_carry_q;
      ext_err_d   = ext_err_q;
      err_count_d = err_count_q;
      if (flush) begin
         // Flush wins over any accept or output transfer on this edge.
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (accept) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = ImmSrc;
            s1_instr_d = Instr;
         end else if (s2_load) begin
            s1_valid_d = 1'b0;
         end
         if (s2_load) begin
            s2_valid_d  = 1'b1;
            ext_imm_d   = imm_calc;
            ext_carry_d = carry_calc;
            ext_err_d   = err_calc;
         end else if (out_xfer) begin
            s2_valid_d = 1'b0;
         end
         if (out_xfer && ext_err_q && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= 3'd0;
         s1_instr_q  <= 24'd0;
         s2_valid_q  <= 1'b0;
         ext_imm_q   <= '0;
         ext_carry_q <= 1'b0;
         ext_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_mode_q   <= s1_mode_d;
         s1_instr_q  <= s1_instr_d;
         s2_valid_q  <= s2_valid_d;
         ext_imm_q   <= ext_imm_d;
         ext_carry_q <= ext_carry_d;
         ext_err_q   <= ext_err_d;
         err_count_q <= err_count_d;
      end
   end

endmodule
